hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the RV32I 5-stage core.
//
// Watches register names, write enables and load/branch status in ID, EX,
// MEM and WB and produces stall, flush and forwarding controls. A two-state
// machine (RUN / MEM_WAIT) freezes the pipeline while a data-memory access
// is outstanding. Saturating counters record stall and flush cycles.
//
// Build option: macro FWD_EN
//   defined   : EX operands forward from MEM/WB; only load-use stalls.
//   undefined : forwarding tied to 00; any EX or MEM writer matching an ID
//               source stalls (WB never stalls, the RF is write-through).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   rs1D, rs2D            ID source registers
//   rs1E, rs2E, rdE       EX source/destination registers
//   rdM, rdW              MEM / WB destination registers
//   RF_WENE/M/W           RF write enables in EX / MEM / WB
//   sel_ldE               EX write-source select, 2'd1 = load
//   br_takenE             branch/jump resolved taken in EX
//   dm_reqM, dm_ackM      data-memory request / acknowledge in MEM
//   stallF/D/E/M          hold PC, IF/ID, ID/EX, EX/MEM
//   flushD, flushE        clear IF/ID, ID/EX
//   fwdAE, fwdBE          ALU operand source: 00 RF, 01 WB, 10 MEM
//   stall_cnt, flush_cnt  saturating stall / branch-flush cycle counters

module hazard_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic             RF_WENE,
    input  logic             RF_WENM,
    input  logic             RF_WENW,
    input  logic [1:0]       sel_ldE,
    input  logic             br_takenE,
    input  logic             dm_reqM,
    input  logic             dm_ackM,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic [1:0]       fwdAE,
    output logic [1:0]       fwdBE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic freeze;
    logic raw_hit;
    logic br_flush;

    // Freeze covers the first unacknowledged request cycle (still in RUN)
    // and every MEM_WAIT cycle up to, but not including, the ack cycle.
    always_comb begin
        freeze  = 1'b0;
        state_d = state_q;
        case (state_q)
            RUN: begin
                freeze = dm_reqM & ~dm_ackM;
                if (dm_reqM && !dm_ackM) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                freeze = ~dm_ackM;
                if (dm_ackM) state_d = RUN;
            end
            default: begin
                freeze  = 1'b0;
                state_d = RUN;
            end
        endcase
    end

    // RAW hazard that forwarding cannot cover.
    logic hitE, hitM;
    always_comb begin
        hitE = RF_WENE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
        hitM = RF_WENM && (rdM != 5'd0) && ((rdM == rs1D) || (rdM == rs2D));
    end

`ifdef FWD_EN
    always_comb begin
        raw_hit = hitE && (sel_ldE == 2'd1);
    end
`else
    always_comb begin
        raw_hit = hitE || hitM;
    end
`endif

    always_comb begin
        stallF   = 1'b0;
        stallD   = 1'b0;
        stallE   = 1'b0;
        stallM   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        br_flush = 1'b0;
        if (rst) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (freeze) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (br_takenE) begin
            flushD   = 1'b1;
            flushE   = 1'b1;
            br_flush = 1'b1;
        end else if (raw_hit) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

`ifdef FWD_EN
    always_comb begin
        fwdAE = 2'b00;
        fwdBE = 2'b00;
        if (!rst) begin
            if (RF_WENM && (rdM != 5'd0) && (rdM == rs1E))      fwdAE = 2'b10;
            else if (RF_WENW && (rdW != 5'd0) && (rdW == rs1E)) fwdAE = 2'b01;
            if (RF_WENM && (rdM != 5'd0) && (rdM == rs2E))      fwdBE = 2'b10;
            else if (RF_WENW && (rdW != 5'd0) && (rdW == rs2E)) fwdBE = 2'b01;
        end
    end
`else
    logic unused_nofwd;
    always_comb begin
        fwdAE        = 2'b00;
        fwdBE        = 2'b00;
        unused_nofwd = ^{rs1E, rs2E, rdW, RF_WENW, sel_ldE};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (stallF && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if (br_flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl. Directed stimulus; each cycle's expected
// controls and counter values are queued when driven and compared at the
// following falling edge. Counters are narrowed to 4 bits so saturation
// is reachable.

module tb_hazard_ctrl;

    localparam int unsigned TB_CNT_W = 4;
    localparam int          CNT_MAX  = (1 << TB_CNT_W) - 1;
`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {stallF, stallD, stallE, stallM, flushD, flushE}
    localparam logic [5:0] C_IDLE = 6'b000000;
    localparam logic [5:0] C_RST  = 6'b000011;
    localparam logic [5:0] C_FRZ  = 6'b111100;
    localparam logic [5:0] C_BR   = 6'b000011;
    localparam logic [5:0] C_LU   = 6'b110001;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic RF_WENE, RF_WENM, RF_WENW;
    logic [1:0] sel_ldE;
    logic br_takenE, dm_reqM, dm_ackM;
    logic stallF, stallD, stallE, stallM, flushD, flushE;
    logic [1:0] fwdAE, fwdBE;
    logic [TB_CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
        .rdE(rdE), .rdM(rdM), .rdW(rdW),
        .RF_WENE(RF_WENE), .RF_WENM(RF_WENM), .RF_WENW(RF_WENW),
        .sel_ldE(sel_ldE), .br_takenE(br_takenE),
        .dm_reqM(dm_reqM), .dm_ackM(dm_ackM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE),
        .fwdAE(fwdAE), .fwdBE(fwdBE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        string       tag;
        logic [5:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        int          sc;
        int          fc;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_sc   = 0;
    int   exp_fc   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.tag, ".ctl"}, 32'({stallF, stallD, stallE, stallM, flushD, flushE}), 32'(e.ctl));
            chk({e.tag, ".fwdA"}, 32'(fwdAE), 32'(e.fa));
            chk({e.tag, ".fwdB"}, 32'(fwdBE), 32'(e.fb));
            chk({e.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.sc));
            chk({e.tag, ".flush_cnt"}, 32'(flush_cnt), 32'(e.fc));
        end
    end

    task automatic clr();
        rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0;
        rdE = '0; rdM = '0; rdW = '0;
        RF_WENE = 1'b0; RF_WENM = 1'b0; RF_WENW = 1'b0;
        sel_ldE = 2'd0; br_takenE = 1'b0; dm_reqM = 1'b0; dm_ackM = 1'b0;
    endtask

    // Queue this cycle's expectation, advance the expected counters from the
    // expected outputs, then move to just after the next rising edge.
    task automatic step(input string tag, input logic [5:0] ctl,
                        input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb;
        e.sc = exp_sc; e.fc = exp_fc;
        sb_q.push_back(e);
        if (rst) begin
            exp_sc = 0;
            exp_fc = 0;
        end else begin
            if (ctl[5] && exp_sc < CNT_MAX) exp_sc++;
            if (ctl[1] && ctl[0] && exp_fc < CNT_MAX) exp_fc++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clr();
        @(posedge clk);
        #1;

        // reset dominates a pending request, a branch and forwarding matches
        dm_reqM = 1'b1; br_takenE = 1'b1;
        rdM = 5'd7; rdW = 5'd7; rs1E = 5'd7; rs2E = 5'd7; RF_WENM = 1'b1; RF_WENW = 1'b1;
        step("rst", C_RST, 2'b00, 2'b00);
        step("rst2", C_RST, 2'b00, 2'b00);
        rst = 1'b0; clr();
        step("idle", C_IDLE, 2'b00, 2'b00);

        // load-use
        sel_ldE = 2'd1; rdE = 5'd5; RF_WENE = 1'b1; rs1D = 5'd5;
        step("lu_rs1", C_LU, 2'b00, 2'b00);
        clr();
        step("after_lu", C_IDLE, 2'b00, 2'b00);
        sel_ldE = 2'd1; rdE = 5'd5; RF_WENE = 1'b1; rs2D = 5'd5;
        step("lu_rs2", C_LU, 2'b00, 2'b00);
        rdE = 5'd0; rs2D = 5'd0;
        step("lu_x0", C_IDLE, 2'b00, 2'b00);
        rdE = 5'd5; rs1D = 5'd5; RF_WENE = 1'b0;
        step("lu_nowen", C_IDLE, 2'b00, 2'b00);

        // forwarding priority
        clr();
        rdM = 5'd7; rdW = 5'd7; rs1E = 5'd7; rs2E = 5'd7; RF_WENM = 1'b1; RF_WENW = 1'b1;
        step("fwd_mem", C_IDLE, FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00);
        RF_WENM = 1'b0;
        step("fwd_wb", C_IDLE, FWD ? 2'b01 : 2'b00, FWD ? 2'b01 : 2'b00);
        rs1E = 5'd0;
        step("fwd_x0", C_IDLE, 2'b00, FWD ? 2'b01 : 2'b00);
        rdM = 5'd7; rdW = 5'd9; rs1E = 5'd9; rs2E = 5'd7; RF_WENM = 1'b1; RF_WENW = 1'b1;
        step("fwd_split", C_IDLE, FWD ? 2'b01 : 2'b00, FWD ? 2'b10 : 2'b00);
        rdW = 5'd0; rs1E = 5'd0; rs2E = 5'd0; rdM = 5'd0;
        step("fwd_allx0", C_IDLE, 2'b00, 2'b00);

        // non-load RAW writers
        clr();
        rdM = 5'd3; RF_WENM = 1'b1; rs2D = 5'd3;
        step("raw_mem", FWD ? C_IDLE : C_LU, 2'b00, 2'b00);
        rdM = 5'd0; RF_WENM = 1'b0; rdW = 5'd3; RF_WENW = 1'b1;
        step("raw_wb", C_IDLE, 2'b00, 2'b00);
        clr();
        sel_ldE = 2'd0; RF_WENE = 1'b1; rdE = 5'd4; rs1D = 5'd4;
        step("raw_alu", FWD ? C_IDLE : C_LU, 2'b00, 2'b00);

        // branch beats load-use
        clr();
        br_takenE = 1'b1; sel_ldE = 2'd1; RF_WENE = 1'b1; rdE = 5'd5; rs1D = 5'd5;
        step("br_lu", C_BR, 2'b00, 2'b00);

        // memory wait: 3 frozen cycles, RUN on the ack cycle
        clr();
        dm_reqM = 1'b1;
        for (int i = 0; i < 3; i++) step("memwait", C_FRZ, 2'b00, 2'b00);
        dm_ackM = 1'b1;
        step("mem_ack", C_IDLE, 2'b00, 2'b00);
        clr();
        step("mem_done", C_IDLE, 2'b00, 2'b00);

        // request acknowledged immediately: no freeze, stays RUN
        dm_reqM = 1'b1; dm_ackM = 1'b1;
        step("req_ack", C_IDLE, 2'b00, 2'b00);
        clr();
        step("req_ack_run", C_IDLE, 2'b00, 2'b00);

        // branch held through a freeze flushes on the ack cycle
        dm_reqM = 1'b1; br_takenE = 1'b1;
        step("br_frz0", C_FRZ, 2'b00, 2'b00);
        step("br_frz1", C_FRZ, 2'b00, 2'b00);
        dm_ackM = 1'b1;
        step("br_release", C_BR, 2'b00, 2'b00);
        clr();
        step("br_done", C_IDLE, 2'b00, 2'b00);

        // freeze beats load-use; load-use resumes on the ack cycle
        dm_reqM = 1'b1; sel_ldE = 2'd1; RF_WENE = 1'b1; rdE = 5'd6; rs2D = 5'd6;
        step("frz_lu", C_FRZ, 2'b00, 2'b00);
        dm_ackM = 1'b1;
        step("frz_lu_rel", C_LU, 2'b00, 2'b00);
        clr();

        // reset mid-freeze
        dm_reqM = 1'b1;
        step("rf_frz0", C_FRZ, 2'b00, 2'b00);
        step("rf_frz1", C_FRZ, 2'b00, 2'b00);
        rst = 1'b1; dm_reqM = 1'b0;
        step("rf_rst", C_RST, 2'b00, 2'b00);
        rst = 1'b0;
        step("rf_run", C_IDLE, 2'b00, 2'b00);

        // counters saturate
        sel_ldE = 2'd1; RF_WENE = 1'b1; rdE = 5'd8; rs1D = 5'd8;
        for (int i = 0; i < 18; i++) step("sat_stall", C_LU, 2'b00, 2'b00);
        clr();
        br_takenE = 1'b1;
        for (int i = 0; i < 17; i++) step("sat_flush", C_BR, 2'b00, 2'b00);
        clr();
        step("sat_end", C_IDLE, 2'b00, 2'b00);

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
